// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the 3-bit FSM state encoding and the default frame data width,
// shared by the parity calculator, the serializer and the transmit controller.
package uart_tx_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Bit-counter width for a given data width (at least one bit).
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/line bundle between a word producer and the UART transmit controller.
//   P_DATA     : parallel word to transmit
//   Data_Valid : P_DATA valid request
//   PAR_EN     : insert a parity bit before the stop bit
//   PAR_bit    : parity bit precomputed for the accepted word
//   TX_OUT     : serial line, idle-high
//   Busy       : high while a frame is in flight
// master = producer side, slave = transmit controller side.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = uart_tx_ctrl_pkg::DEFAULT_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_bit;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output PAR_bit,
      input  TX_OUT,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  PAR_bit,
      output TX_OUT,
      output Busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the UART data phase.
//   clk, reset : clock, async active-low reset
//   load       : capture load_data, arm the counter
//   shift_en   : shift one bit toward the LSB, advance the counter
//   load_data  : word to serialize
//   ser_data   : bit to be driven on the line at the coming edge
//   ser_done   : the bit currently on the line is the last data bit
module uart_tx_serializer
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  ser_data,
   output logic                  ser_done
);

   localparam int             CW   = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         bit_cnt;

   // The counter is preset to LAST on load so that the shift on the edge
   // leaving START rolls it to 0 as bit 0 goes on the line; it then holds the
   // index of the bit currently on the line, and wraps back to 0 on the edge
   // that leaves the data phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= load_data;
         bit_cnt <= LAST;
      end else if (shift_en) begin
         shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
         bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      end
   end

   assign ser_data = shreg[0];
   assign ser_done = (bit_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames an accepted word as
// start, DATA_WIDTH data bits (LSB first), optional parity, stop.
// One bit period per clk cycle.
//   clk   : transmit clock
//   reset : async active-low reset, aborts any frame in flight
//   bus   : request/line bundle (slave side)
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (0) on the line
// DATA   | data bits on the line, LSB first
// PARITY | latched PAR_bit on the line
// STOP   | stop bit (1) on the line, still busy
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   uart_tx_ctrl_if.slave   bus
);

   tx_state_e state;
   logic      tx_out_q;
   logic      busy_q;
   logic      par_en_q;
   logic      load;
   logic      shift_en;
   logic      ser_data;
   logic      ser_done;

   assign load     = (state == IDLE) && bus.Data_Valid;
   assign shift_en = (state == START) || (state == DATA);

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .shift_en  (shift_en),
      .load_data (bus.P_DATA),
      .ser_data  (ser_data),
      .ser_done  (ser_done)
   );

   // Outputs are loaded with the value belonging to the state being entered,
   // so TX_OUT/Busy line up cycle-for-cycle with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Data_Valid) begin
                  state    <= START;
                  tx_out_q <= 1'b0;
                  busy_q   <= 1'b1;
                  par_en_q <= bus.PAR_EN;
               end else begin
                  tx_out_q <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            START: begin
               state    <= DATA;
               tx_out_q <= ser_data;
            end
            DATA: begin
               if (ser_done) begin
                  if (par_en_q) begin
                     state    <= PARITY;
                     tx_out_q <= bus.PAR_bit;
                  end else begin
                     state    <= STOP;
                     tx_out_q <= 1'b1;
                  end
               end else begin
                  tx_out_q <= ser_data;
               end
            end
            PARITY: begin
               state    <= STOP;
               tx_out_q <= 1'b1;
            end
            STOP: begin
               state    <= IDLE;
               tx_out_q <= 1'b1;
               busy_q   <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               tx_out_q <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.TX_OUT = tx_out_q;
   assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl. The driver issues one input vector per
// cycle (at the falling edge) and queues the TX_OUT/Busy pair expected after
// the next rising edge; the monitor pops and compares after every rising edge.
module tb_uart_tx_ctrl;

   typedef struct {
      logic  tx;
      logic  busy;
      string tag;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   string cur_tag;
   exp_t  exp_q[$];

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus_if ();

   uart_tx_ctrl #(
      .DATA_WIDTH (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: one expected pair per rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus_if.TX_OUT !== e.tx || bus_if.Busy !== e.busy) begin
            errors++;
            $display("FAIL %s @%0t: TX_OUT/Busy got %b/%b expected %b/%b",
                     e.tag, $time, bus_if.TX_OUT, bus_if.Busy, e.tx, e.busy);
         end
      end
   end

   task automatic step(input logic rst, input logic dv, input logic [7:0] d,
                       input logic pe, input logic pb,
                       input logic etx, input logic ebusy);
      exp_t e;
      @(negedge clk);
      reset             = rst;
      bus_if.Data_Valid = dv;
      bus_if.P_DATA     = d;
      bus_if.PAR_EN     = pe;
      bus_if.PAR_bit    = pb;
      e.tx   = etx;
      e.busy = ebusy;
      e.tag  = cur_tag;
      exp_q.push_back(e);
   endtask

   task automatic check_now(input logic etx, input logic ebusy, input string tag);
      checks++;
      if (bus_if.TX_OUT !== etx || bus_if.Busy !== ebusy) begin
         errors++;
         $display("FAIL %s @%0t: TX_OUT/Busy got %b/%b expected %b/%b",
                  tag, $time, bus_if.TX_OUT, bus_if.Busy, etx, ebusy);
      end
   endtask

   // One frame: request on the first step, seq[i] expected on the line after
   // edge i, then one STOP->IDLE step expecting (1,0). From mid_idx onward
   // (if >= 0) P_DATA/PAR_EN switch to mid_d/mid_pe and Data_Valid pulses once.
   task automatic frame(input logic [7:0] d, input logic pe, input logic pb,
                        input logic [15:0] seq, input int len, input logic hold,
                        input int mid_idx, input logic [7:0] mid_d, input logic mid_pe);
      for (int i = 0; i < len; i++) begin
         logic       dv_i;
         logic [7:0] d_i;
         logic       pe_i;
         dv_i = (i == 0) || hold || (i == mid_idx);
         d_i  = (mid_idx >= 0 && i >= mid_idx) ? mid_d  : d;
         pe_i = (mid_idx >= 0 && i >= mid_idx) ? mid_pe : pe;
         step(1'b1, dv_i, d_i, pe_i, pb, seq[i], 1'b1);
      end
      step(1'b1, hold, d, pe, pb, 1'b1, 1'b0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      cur_tag = "reset";
      reset             = 1'b1;
      bus_if.Data_Valid = 1'b0;
      bus_if.P_DATA     = 8'h00;
      bus_if.PAR_EN     = 1'b0;
      bus_if.PAR_bit    = 1'b0;
      #1 reset = 1'b0;
      #1 check_now(1'b1, 1'b0, "reset_state");
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // 0xA5 with parity 0: 0,1,0,1,0,0,1,0,1,0,1
      cur_tag = "a5_par";
      frame(8'hA5, 1'b1, 1'b0, 16'b101_0100_1010, 11, 1'b0, -1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // 0x3C, no parity: 0,0,0,1,1,1,1,0,0,1
      cur_tag = "3c_nopar";
      frame(8'h3C, 1'b0, 1'b1, 16'b10_0111_1000, 10, 1'b0, -1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Data_Valid held high: 0x01 then 0x80, one idle cycle between
      cur_tag = "held_01";
      frame(8'h01, 1'b0, 1'b0, 16'b10_0000_0010, 10, 1'b1, -1, 8'h00, 1'b0);
      cur_tag = "held_80";
      frame(8'h80, 1'b0, 1'b0, 16'b11_0000_0000, 10, 1'b0, -1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // 0x00 frame, Data_Valid pulse and P_DATA=0xFF during DATA
      cur_tag = "00_midchange";
      frame(8'h00, 1'b0, 1'b0, 16'b10_0000_0000, 10, 1'b0, 4, 8'hFF, 1'b0);
      cur_tag = "00_no_extra";
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

      // PAR_EN dropped during DATA, PAR_bit=1: 0,1,0,0,0,0,0,0,0,1,1
      cur_tag = "par_en_latched";
      frame(8'h01, 1'b1, 1'b1, 16'b110_0000_0010, 11, 1'b0, 3, 8'h01, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset during data bit 3 of 0xA5
      cur_tag = "a5_abort";
      step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      cur_tag = "abort_reset";
      step(1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 check_now(1'b1, 1'b0, "abort_immediate");
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // 0x5A with parity 0 after release: 0,0,1,0,1,1,0,1,0,0,1
      cur_tag = "5a_after_reset";
      frame(8'h5A, 1'b1, 1'b0, 16'b100_1011_0100, 11, 1'b0, -1, 8'h00, 1'b0);
      cur_tag = "tail_idle";
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 Port: clk  in  1  single transmit clock (one bit period per clk cycle).
REQ-003 Port: reset  in  1  reset; asynchronous, active-low.
REQ-004 Port: P_DATA  in  DATA_WIDTH  parallel byte to transmit.
REQ-005 Port: Data_Valid  in  1  P_DATA valid request.
REQ-006 Port: PAR_EN  in  1  1 = insert a parity bit between the data bits and the stop bit.
REQ-007 Port: PAR_bit  in  1  parity bit from the parity calculator stage, already computed for the accepted word.
REQ-008 Port: TX_OUT  out  1  serial line, registered, idle-high.
REQ-009 Port: Busy  out  1  registered; high while a frame is in flight.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE with Data_Valid=1, the block SHALL accept the request: latch P_DATA into the shift register, latch PAR_EN, and go to START at the next edge.
REQ-012 Data_Valid SHALL be ignored in every state other than IDLE, and P_DATA changes after acceptance SHALL NOT affect the frame.
REQ-013 START SHALL last 1 cycle with TX_OUT=0, then the block SHALL go to DATA.
REQ-014 DATA SHALL last DATA_WIDTH cycles and drive the data LSB first, one bit per cycle, from a bit counter running 0..DATA_WIDTH-1.
REQ-015 When the counter reaches DATA_WIDTH-1, the block SHALL go to PARITY if the latched PAR_EN=1, otherwise to STOP; the counter SHALL clear.
REQ-016 PARITY SHALL last 1 cycle with TX_OUT equal to PAR_bit, sampled at the edge entering PARITY.
REQ-017 STOP SHALL last 1 cycle with TX_OUT=1, then the block SHALL go to IDLE.
REQ-018 TX_OUT SHALL be 1 in IDLE.
REQ-019 TX_OUT and Busy SHALL be registered, decoded from the next state, so each output value is aligned with the state it belongs to.
REQ-020 Latency: if Data_Valid is sampled at edge k, TX_OUT SHALL be 0 (start bit) and Busy SHALL be 1 from edge k+1.
REQ-021 Busy SHALL stay 1 through STOP and SHALL drop at the edge entering IDLE.
REQ-022 Frame length SHALL be 1+DATA_WIDTH+PAR_EN+1 cycles.
REQ-023 With Data_Valid held high, frames SHALL be separated by exactly one IDLE cycle (TX_OUT=1, Busy=0). The next request is accepted in that cycle.
REQ-024 The PAR_bit producer SHALL hold PAR_bit stable from the cycle after acceptance until PARITY is entered. This block SHALL NOT compute parity.

Reset
REQ-025 On reset=0, the block SHALL asynchronously force state=IDLE, TX_OUT=1, Busy=0, bit counter=0, shift register=0 and latched PAR_EN=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no partial completion.
REQ-027 After reset deasserts, the first edge with Data_Valid=1 SHALL be accepted normally.

Structure
REQ-028 State encodings (3-bit) and the default DATA_WIDTH SHALL live in the shared UART TX package/include, also used by the parity calculator and the top-level.
REQ-029 One sub-module, uart_tx_serializer, SHALL hold the shift register and bit counter.
- Inputs: load, shift enable.
- Outputs: ser_data, ser_done.
REQ-030 The FSM and the output register SHALL remain in uart_tx_ctrl.

Verification
REQ-031 PAR_EN=1, P_DATA=0xA5, PAR_bit=0, one Data_Valid pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high for exactly 11 cycles, then TX_OUT=1.
REQ-032 PAR_EN=0, P_DATA=0x3C -> TX_OUT = 0,0,0,1,1,1,1,0,0,1 over 10 cycles; no parity slot; Busy high for 10 cycles.
REQ-033 Data_Valid held high, P_DATA=0x01 then 0x80, PAR_EN=0 -> two 10-cycle frames separated by exactly one cycle of TX_OUT=1, Busy=0.
REQ-034 Data_Valid pulsed and P_DATA changed to 0xFF during the DATA state of a 0x00 frame -> frame bits all 0, no extra frame, Busy timing unchanged.
REQ-035 reset pulsed low during data bit 3 of 0xA5 -> TX_OUT=1 and Busy=0 immediately; a new 0x5A request after release transmits a full, correct frame.
REQ-036 PAR_EN toggled 1->0 during DATA (latched PAR_EN=1), PAR_bit=1 -> parity slot still present and equal to 1.
